program_loader: RTL and testbench

Front-end block that owns the processor's instruction memory and the processor's run control. It accepts a program as a byte stream over a valid/ready handshake and writes it into the 256-byte instruction memory array consumed by `main`. It then releases the processor to execute and watches `next_instruction` to stop the run after a configurable number of consecutive NOPs.

---
 rtl/program_loader_if.sv | 11 +
 rtl/program_loader.sv | 110 +++++++++++
 tb/tb_program_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream load channel into the program loader: valid/ready handshake
// with a last-byte qualifier.
interface program_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, output byte_last, input byte_ready);
    modport slave  (input byte_data, input byte_valid, input byte_last, output byte_ready);
endinterface

// File: rtl/program_loader.sv
// Instruction-memory loader and run control: writes a word-ordered MSB-first
// byte stream into memory, releases the CPU, and halts it after NOP_HALT NOPs.
module program_loader #(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned NOP_HALT  = 4
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                load_start_i,
    program_loader_if.slave     bus,
    output logic [7:0]          instruction_mem_o [MEM_BYTES],
    input  logic [31:0]         next_instruction_i,
    output logic                cpu_run_o,
    output logic                halted_o,
    output logic [8:0]          byte_count_o,
    output logic                load_error_o
);
    localparam int unsigned AW = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_e;

    state_e      state_q, state_d;
    logic [8:0]  count_q, count_d;
    logic        err_q, err_d;
    logic [3:0]  nop_q, nop_d;
    logic [7:0]  mem_q [MEM_BYTES];
    logic        mem_clr, mem_we;
    logic [AW-1:0] wr_addr;

    // Byte k lands at 4*(k/4) + 3 - k%4, which is k with its two LSBs inverted.
    assign wr_addr = AW'(count_q) ^ AW'(3);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        nop_d   = nop_q;
        mem_clr = 1'b0;
        mem_we  = 1'b0;
        if (load_start_i) begin
            state_d = S_LOAD;
            count_d = '0;
            err_d   = 1'b0;
            nop_d   = '0;
            mem_clr = 1'b1;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (bus.byte_valid) begin
                        if (count_q == 9'(MEM_BYTES)) begin
                            err_d = 1'b1;
                        end else begin
                            mem_we  = 1'b1;
                            count_d = count_q + 9'd1;
                        end
                        if (bus.byte_last) begin
                            state_d = S_RUN;
                            nop_d   = '0;
                            if (count_d[1:0] != 2'b00) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (next_instruction_i == 32'd0) begin
                        nop_d = (nop_q == 4'hF) ? nop_q : nop_q + 4'd1;
                    end else begin
                        nop_d = '0;
                    end
                    if (nop_d == 4'(NOP_HALT)) begin
                        state_d = S_HALT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            nop_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            nop_q   <= nop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni || mem_clr) begin
            for (int unsigned i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[wr_addr] <= bus.byte_data;
        end
    end

    assign instruction_mem_o = mem_q;
    assign bus.byte_ready    = (state_q == S_LOAD);
    assign cpu_run_o         = (state_q == S_RUN);
    assign halted_o          = (state_q == S_HALT);
    assign byte_count_o      = count_q;
    assign load_error_o      = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: memory image, run/halt control,
// overflow, partial word, reset and restart behaviour.
module tb_program_loader;
    localparam int unsigned MEM_BYTES = 256;
    localparam int unsigned NOP_HALT  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_start;
    logic [31:0] next_instr;
    logic        cpu_run, halted, load_error;
    logic [8:0]  byte_count;
    logic [7:0]  imem [MEM_BYTES];

    always #5 clk = ~clk;

    program_loader_if bus();

    program_loader #(.MEM_BYTES(MEM_BYTES), .NOP_HALT(NOP_HALT)) dut (
        .clk_i              (clk),
        .reset_ni           (reset_n),
        .load_start_i       (load_start),
        .bus                (bus),
        .instruction_mem_o  (imem),
        .next_instruction_i (next_instr),
        .cpu_run_o          (cpu_run),
        .halted_o           (halted),
        .byte_count_o       (byte_count),
        .load_error_o       (load_error)
    );

    typedef struct {
        int unsigned addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         sb[$];
    logic [7:0]  exp_mem [MEM_BYTES];
    int unsigned exp_count;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(MEM_BYTES); i++) exp_mem[i] = 8'h00;
        exp_count = 0;
        sb.delete();
    endtask

    // Drive one byte for one cycle; the model records it if it fits.
    task automatic send(input logic [7:0] d, input logic last);
        int unsigned a;
        bus.byte_data  = d;
        bus.byte_valid = 1'b1;
        bus.byte_last  = last;
        step();
        if (exp_count < MEM_BYTES) begin
            a = 4 * (exp_count / 4) + 3 - (exp_count % 4);
            exp_mem[a] = d;
            sb.push_back('{addr: a, data: d});
            exp_count++;
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
    endtask

    task automatic drain_sb();
        wr_t w;
        while (sb.size() > 0) begin
            w = sb.pop_front();
            chk($sformatf("mem[%0d]", w.addr), 32'(imem[w.addr]), 32'(w.data));
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            chk($sformatf("%s mem[%0d]", tag, i), 32'(imem[i]), 32'(exp_mem[i]));
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        model_clear();
    endtask

    logic [7:0] prog [8];

    initial begin
        prog = '{8'h20, 8'h0A, 8'h00, 8'h0A, 8'h20, 8'h0C, 8'h00, 8'h0B};
        reset_n        = 1'b0;
        load_start     = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        next_instr     = 32'h200A000A;
        model_clear();

        // Reset state
        step();
        step();
        chk("rst ready", 32'(bus.byte_ready), 32'd0);
        chk("rst cpu_run", 32'(cpu_run), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst err", 32'(load_error), 32'd0);
        chk("rst count", 32'(byte_count), 32'd0);
        check_mem("rst");
        reset_n = 1'b1;
        step();
        chk("idle ready", 32'(bus.byte_ready), 32'd0);

        // Eight-byte program
        pulse_start();
        chk("start ready", 32'(bus.byte_ready), 32'd1);
        chk("start count", 32'(byte_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            send(prog[i], i == 7);
            if (i == 6) chk("pre-last cpu_run", 32'(cpu_run), 32'd0);
        end
        chk("prog cpu_run", 32'(cpu_run), 32'd1);
        chk("prog ready", 32'(bus.byte_ready), 32'd0);
        chk("prog count", 32'(byte_count), 32'd8);
        chk("prog err", 32'(load_error), 32'd0);
        chk("prog mem3", 32'(imem[3]), 32'h20);
        chk("prog mem0", 32'(imem[0]), 32'h0A);
        chk("prog mem7", 32'(imem[7]), 32'h20);
        chk("prog mem4", 32'(imem[4]), 32'h0B);
        drain_sb();

        // NOP detection with a restart after three zeros
        step();
        next_instr = 32'd0;
        for (int i = 0; i < 3; i++) step();
        chk("3 nops cpu_run", 32'(cpu_run), 32'd1);
        next_instr = 32'h0000_0001;
        step();
        next_instr = 32'd0;
        for (int i = 0; i < 3; i++) step();
        chk("restart cpu_run", 32'(cpu_run), 32'd1);
        chk("restart halted", 32'(halted), 32'd0);
        step();
        chk("halt cpu_run", 32'(cpu_run), 32'd0);
        chk("halt halted", 32'(halted), 32'd1);
        chk("halt count", 32'(byte_count), 32'd8);
        check_mem("halt");
        next_instr = 32'h200A000A;

        // load_start in HALT with a coincident byte
        load_start     = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h77;
        step();
        load_start     = 1'b0;
        bus.byte_valid = 1'b0;
        model_clear();
        chk("rehalt halted", 32'(halted), 32'd0);
        chk("rehalt ready", 32'(bus.byte_ready), 32'd1);
        chk("rehalt cpu_run", 32'(cpu_run), 32'd0);
        chk("rehalt count", 32'(byte_count), 32'd0);
        chk("rehalt err", 32'(load_error), 32'd0);
        check_mem("rehalt");

        // Overflow: 257 bytes
        for (int i = 0; i < 257; i++) begin
            send(8'hA5, i == 256);
            if (i == 255) begin
                chk("full count", 32'(byte_count), 32'd256);
                chk("full err", 32'(load_error), 32'd0);
            end
        end
        chk("ovf count", 32'(byte_count), 32'd256);
        chk("ovf err", 32'(load_error), 32'd1);
        chk("ovf cpu_run", 32'(cpu_run), 32'd1);
        drain_sb();

        // Partial final word, starting from RUN
        pulse_start();
        chk("abort cpu_run", 32'(cpu_run), 32'd0);
        chk("abort ready", 32'(bus.byte_ready), 32'd1);
        chk("abort err", 32'(load_error), 32'd0);
        for (int i = 0; i < 6; i++) send(8'(8'h11 + i), i == 5);
        chk("part err", 32'(load_error), 32'd1);
        chk("part count", 32'(byte_count), 32'd6);
        chk("part cpu_run", 32'(cpu_run), 32'd1);
        chk("part mem7", 32'(imem[7]), 32'h15);
        chk("part mem6", 32'(imem[6]), 32'h16);
        chk("part mem5", 32'(imem[5]), 32'h00);
        chk("part mem4", 32'(imem[4]), 32'h00);
        drain_sb();
        check_mem("part");

        // load_start in LOAD with a coincident byte
        pulse_start();
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        chk("pre-restart count", 32'(byte_count), 32'd2);
        load_start     = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h99;
        step();
        load_start     = 1'b0;
        bus.byte_valid = 1'b0;
        model_clear();
        chk("restart count", 32'(byte_count), 32'd0);
        chk("restart ready", 32'(bus.byte_ready), 32'd1);
        check_mem("restart");

        // Reset mid-load with byte_valid held high
        for (int i = 0; i < 3; i++) send(8'(8'h41 + i), 1'b0);
        chk("midload count", 32'(byte_count), 32'd3);
        reset_n        = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        step();
        model_clear();
        chk("mrst ready", 32'(bus.byte_ready), 32'd0);
        chk("mrst cpu_run", 32'(cpu_run), 32'd0);
        chk("mrst halted", 32'(halted), 32'd0);
        chk("mrst err", 32'(load_error), 32'd0);
        chk("mrst count", 32'(byte_count), 32'd0);
        check_mem("mrst");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("post-rst count", 32'(byte_count), 32'd0);
        chk("post-rst ready", 32'(bus.byte_ready), 32'd0);
        check_mem("post-rst");
        bus.byte_valid = 1'b0;
        pulse_start();
        chk("reload ready", 32'(bus.byte_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
